// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
//   Shared constants for the show-ahead FIFO slice.
//   RAM_RD_LATENCY : registered read latency of ram_block, in clocks
//   OUTQ_DEPTH     : depth of the register output queue that hides that latency
//   usedWidth()    : bits needed to hold the largest fill count the FIFO can reach
package ram_fifo_pkg;

   localparam int RAM_RD_LATENCY = 2;
   localparam int OUTQ_DEPTH     = RAM_RD_LATENCY + 1;

   // clog2(2**addrWidth + OUTQ_DEPTH + 1): counts how many powers of two lie
   // below the value, which is exactly the number of bits required.
   function automatic int usedWidth(input int addrWidth);
      int value;
      int bits;
      value = (1 << addrWidth) + OUTQ_DEPTH + 1;
      bits  = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) < value) bits++;
      end
      return bits;
   endfunction

endpackage

// File: rtl/ram_block.sv
// ram_block
//   Simple dual-port RAM, one write port and one read port on a single clock.
//   The read address and the read data are both registered, so data for an
//   address presented in cycle N appears on q after the second following edge.
//   Contents are not reset.
//   clk        : clock, rising edge
//   data       : write data
//   wraddress  : write address
//   wren       : write enable
//   rdaddress  : read address (sampled every edge)
//   q          : registered read data
module ram_block #(
   parameter int DAT_WIDTH  = 36,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic [DAT_WIDTH-1:0]  data,
   input  logic [ADDR_WIDTH-1:0] wraddress,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] rdaddress,
   output logic [DAT_WIDTH-1:0]  q
);

   logic [DAT_WIDTH-1:0]  mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] rdAddr_q;
   logic [DAT_WIDTH-1:0]  q_q;

   // Write port plus the two read register stages; no reset on storage.
   always_ff @(posedge clk) begin
      if (wren) mem[wraddress] <= data;
      rdAddr_q <= rdaddress;
      q_q      <= mem[rdAddr_q];
   end

   assign q = q_q;

endmodule

// File: rtl/ram_fifo_outq.sv
// ram_fifo_outq
//   Three-entry register queue in FIFO order. Entry 0 is always the head, so
//   the head word and its valid flag come straight from registers.
//   clk         : clock, rising edge
//   arst        : asynchronous reset, active-high; empties the queue
//   push_i      : write pushData_i at the tail this edge
//   pushData_i  : word to enqueue
//   pop_i       : drop the head this edge (ignored when empty)
//   headData_o  : head word
//   headValid_o : queue holds at least one word
//   count_o     : number of words held, 0..3
module ram_fifo_outq
   import ram_fifo_pkg::*;
#(
   parameter int DAT_WIDTH = 36
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 push_i,
   input  logic [DAT_WIDTH-1:0] pushData_i,
   input  logic                 pop_i,
   output logic [DAT_WIDTH-1:0] headData_o,
   output logic                 headValid_o,
   output logic [1:0]           count_o
);

   logic [DAT_WIDTH-1:0] entry_q [OUTQ_DEPTH];
   logic [DAT_WIDTH-1:0] entry_d [OUTQ_DEPTH];
   logic [1:0]           cnt_q, cnt_d;
   logic [1:0]           slot;
   logic                 popEff;

   // A pop shifts every entry one place toward the head; a push lands in the
   // first free slot after that shift, which makes push into an empty queue
   // and push+pop on a full queue fall out of the same rule.
   always_comb begin
      entry_d = entry_q;
      popEff  = pop_i & (cnt_q != 2'd0);
      slot    = cnt_q - {1'b0, popEff};
      if (popEff) begin
         for (int i = 0; i < OUTQ_DEPTH - 1; i++) begin
            entry_d[i] = entry_q[i+1];
         end
      end
      if (push_i && (slot < 2'(OUTQ_DEPTH))) entry_d[slot] = pushData_i;
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, popEff};
   end

   // Queue registers; entries are cleared so the head reads zero after reset.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < OUTQ_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign headData_o  = entry_q[0];
   assign headValid_o = (cnt_q != 2'd0);
   assign count_o     = cnt_q;

endmodule

// File: rtl/ram_fifo_showahead.sv
// ram_fifo_showahead
//   Show-ahead FIFO wrapped around ram_block. Words are written into the RAM,
//   prefetched through its two-cycle read pipe and parked in a three-entry
//   register queue, so dout always shows the oldest word without a read delay.
//   clk      : clock, rising edge
//   arst     : asynchronous reset, active-high; discards all stored words
//   din      : write data
//   wr_valid : write request, accepted when wr_ready is also high
//   wr_ready : RAM has room
//   dout     : head word
//   rd_valid : dout holds a valid word
//   rd_ready : pop the head when rd_valid is high
//   used     : words held in RAM, read pipe and output queue together
module ram_fifo_showahead
   import ram_fifo_pkg::*;
#(
   parameter int DAT_WIDTH  = 36,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [DAT_WIDTH-1:0]  din,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DAT_WIDTH-1:0]  dout,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH+1:0] used
);

   localparam int                  USED_W   = usedWidth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0]     wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0]     rdPtr_q, rdPtr_d;
   logic [ADDR_WIDTH:0]       ramCnt_q, ramCnt_d;
   logic [RAM_RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [ADDR_WIDTH+1:0]     used_q, used_d;
   logic [USED_W-1:0]         usedSum;
   logic [DAT_WIDTH-1:0]      ramQ;
   logic [1:0]                qCnt, qCnt_d;
   logic [1:0]                inflight, inflight_d;
   logic [2:0]                credit;
   logic                      wren, issue, pop, push;

   assign wr_ready = (ramCnt_q != FULL_CNT);
   assign wren     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;
   assign push     = pipe_q[RAM_RD_LATENCY-1];
   assign inflight = {1'b0, pipe_q[1]} + {1'b0, pipe_q[0]};

   // A read is only issued when the word is guaranteed a queue slot on
   // arrival: everything already in flight or queued, less this cycle's pop,
   // must leave room. ramCnt_q excludes this cycle's write, so the read never
   // targets the address being written right now.
   always_comb begin
      credit = {1'b0, inflight} + {1'b0, qCnt} - {2'b00, pop};
      issue  = (ramCnt_q != '0) & (credit < 3'd3);
   end

   // Next-state for pointers, RAM count, read pipe and the registered fill
   // count. used is built from next-state values so it always describes the
   // state that exists after the edge.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      if (wren)  wrPtr_d = wrPtr_q + 1'b1;
      if (issue) rdPtr_d = rdPtr_q + 1'b1;
      ramCnt_d   = ramCnt_q + (ADDR_WIDTH+1)'(wren) - (ADDR_WIDTH+1)'(issue);
      pipe_d     = {pipe_q[0], issue};
      inflight_d = {1'b0, pipe_d[1]} + {1'b0, pipe_d[0]};
      qCnt_d     = qCnt + {1'b0, push} - {1'b0, pop};
      usedSum    = USED_W'(ramCnt_d) + USED_W'(inflight_d) + USED_W'(qCnt_d);
      used_d     = (ADDR_WIDTH+2)'(usedSum);
   end

   // Control state; clearing the pipe also drops any read still returning.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         ramCnt_q <= '0;
         pipe_q   <= '0;
         used_q   <= '0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         ramCnt_q <= ramCnt_d;
         pipe_q   <= pipe_d;
         used_q   <= used_d;
      end
   end

   assign used = used_q;

   ram_block #(
      .DAT_WIDTH  (DAT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) uRam (
      .clk       (clk),
      .data      (din),
      .wraddress (wrPtr_q),
      .wren      (wren),
      .rdaddress (rdPtr_q),
      .q         (ramQ)
   );

   ram_fifo_outq #(
      .DAT_WIDTH (DAT_WIDTH)
   ) uOutq (
      .clk         (clk),
      .arst        (arst),
      .push_i      (push),
      .pushData_i  (ramQ),
      .pop_i       (pop),
      .headData_o  (dout),
      .headValid_o (rd_valid),
      .count_o     (qCnt)
   );

endmodule

// File: tb/tb_ram_fifo_showahead.sv
// tb_ram_fifo_showahead
//   Bench for ram_fifo_showahead with a small (8-word) RAM so that full and
//   wrap conditions are reached quickly. The reference model is a plain queue
//   of accepted words: used must equal its size, popped data must match its
//   front, and flow control must agree with its fill level.
module tb_ram_fifo_showahead;

   localparam int DW    = 36;
   localparam int AW    = 3;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          arst;
   logic [DW-1:0] din;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] dout;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW+1:0] used;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb [$];

   typedef struct {
      logic          wrValid;
      logic [DW-1:0] data;
      logic          rdReady;
      logic          expWrReady;
      logic          expRdValid;
      logic [AW+1:0] expUsed;
      logic          chkDout;
      logic [DW-1:0] expDout;
   } vector_t;

   vector_t vecs [12];

   ram_fifo_showahead #(
      .DAT_WIDTH  (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .arst     (arst),
      .din      (din),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .dout     (dout),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .used     (used)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports it when actual differs.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Hold reset across two edges and release it away from the edge.
   task automatic applyReset();
      arst     = 1'b1;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      din      = '0;
      repeat (2) @(posedge clk);
      #1 arst = 1'b0;
      sb.delete();
   endtask

   // Flow-control rules that follow from the model's fill level alone.
   task automatic checkInvariants();
      if (sb.size() == 0)         checkOutput("rd_valid while empty", rd_valid, 0);
      if (sb.size() < DEPTH)      checkOutput("wr_ready with space", wr_ready, 1);
      if (sb.size() == DEPTH + 3) checkOutput("wr_ready when full", wr_ready, 0);
   endtask

   // Apply the currently driven inputs for one clock, keeping the model in step.
   task automatic applyStimulus();
      logic acc;
      logic pp;
      acc = wr_valid & wr_ready;
      pp  = rd_valid & rd_ready;
      if (dut.wren && dut.issue)
         checkOutput("rdaddress vs wraddress", 64'(dut.rdPtr_q != dut.wrPtr_q), 1);
      if (pp) begin
         if (sb.size() == 0) checkOutput("pop with nothing stored", rd_valid, 0);
         else begin
            checkOutput("pop data", dout, sb[0]);
            void'(sb.pop_front());
         end
      end
      if (acc) sb.push_back(din);
      @(posedge clk);
      #1;
      checkOutput("used", used, sb.size());
      checkInvariants();
   endtask

   // Pop everything that is left, within a fixed cycle budget.
   task automatic drainAll();
      int budget;
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      budget   = 60;
      while (sb.size() > 0 && budget > 0) begin
         applyStimulus();
         budget--;
      end
      checkOutput("drain complete", sb.size(), 0);
      rd_ready = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] nextData;
      logic          willAccept;
      logic [63:0]   r;
      int            budget;
      logic          seen;

      // Single word, then two words held back and released; one row per edge.
      vecs[0]  = '{1, 36'h5A5A5A5A5, 1, 1, 0, 1, 0, 0};
      vecs[1]  = '{0, 0, 1, 1, 0, 1, 0, 0};
      vecs[2]  = '{0, 0, 1, 1, 0, 1, 0, 0};
      vecs[3]  = '{0, 0, 1, 1, 1, 1, 1, 36'h5A5A5A5A5};
      vecs[4]  = '{0, 0, 1, 1, 0, 0, 0, 0};
      vecs[5]  = '{1, 36'h123456789, 0, 1, 0, 1, 0, 0};
      vecs[6]  = '{1, 36'hABCDEF012, 0, 1, 0, 2, 0, 0};
      vecs[7]  = '{0, 0, 0, 1, 0, 2, 0, 0};
      vecs[8]  = '{0, 0, 0, 1, 1, 2, 1, 36'h123456789};
      vecs[9]  = '{0, 0, 0, 1, 1, 2, 1, 36'h123456789};
      vecs[10] = '{0, 0, 1, 1, 1, 1, 1, 36'hABCDEF012};
      vecs[11] = '{0, 0, 1, 1, 0, 0, 0, 0};

      // Reset and idle.
      applyReset();
      checkOutput("reset dout", dout, 0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("idle wren", dut.wren, 0);
         @(posedge clk);
         #1;
         checkOutput("idle wr_ready", wr_ready, 1);
         checkOutput("idle rd_valid", rd_valid, 0);
         checkOutput("idle used", used, 0);
      end

      // Table-driven latency vectors.
      for (int i = 0; i < 12; i++) begin
         wr_valid = vecs[i].wrValid;
         din      = vecs[i].data;
         rd_ready = vecs[i].rdReady;
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d wr_ready", i), wr_ready, vecs[i].expWrReady);
         checkOutput($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].expRdValid);
         checkOutput($sformatf("vec%0d used", i), used, vecs[i].expUsed);
         if (vecs[i].chkDout) checkOutput($sformatf("vec%0d dout", i), dout, vecs[i].expDout);
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;

      // Fill to capacity with reads stalled, then drain with no gaps.
      applyReset();
      nextData = '0;
      wr_valid = 1'b1;
      for (int a = 0; a < 21; a++) begin
         din        = nextData;
         willAccept = wr_ready;
         applyStimulus();
         if (willAccept) nextData++;
      end
      wr_valid = 1'b0;
      checkOutput("fill accepted", sb.size(), DEPTH + 3);
      checkOutput("fill wr_ready", wr_ready, 0);
      rd_ready = 1'b1;
      for (int k = 0; k < DEPTH + 3; k++) begin
         checkOutput("drain rd_valid", rd_valid, 1);
         checkOutput("drain dout", dout, k);
         applyStimulus();
      end
      checkOutput("drain empty rd_valid", rd_valid, 0);
      rd_ready = 1'b0;

      // Full-rate streaming across many pointer wraps.
      applyReset();
      nextData = '0;
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         din        = nextData;
         willAccept = wr_ready;
         applyStimulus();
         if (willAccept) nextData++;
         if (c >= 3) checkOutput("stream rd_valid", rd_valid, 1);
      end
      checkOutput("stream accepted all", nextData, 1000);
      drainAll();

      // Random traffic against the queue model.
      for (int c = 0; c < 10000; c++) begin
         wr_valid = 1'($urandom_range(0, 1));
         rd_ready = 1'($urandom_range(0, 1));
         r        = {$urandom(), $urandom()};
         din      = r[DW-1:0];
         applyStimulus();
      end
      drainAll();

      // Asynchronous reset with reads in flight.
      applyReset();
      nextData = '0;
      wr_valid = 1'b1;
      budget   = 30;
      while (wr_ready && budget > 0) begin
         din = nextData;
         applyStimulus();
         nextData++;
         budget--;
      end
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      budget   = 20;
      while (!(dut.inflight == 2'd2 && used == 5'd9) && budget > 0) begin
         applyStimulus();
         budget--;
      end
      checkOutput("reached inflight=2 used=9", budget > 0, 1);
      #2 arst = 1'b1;
      #1;
      checkOutput("arst rd_valid", rd_valid, 0);
      checkOutput("arst used", used, 0);
      checkOutput("arst wr_ready", wr_ready, 1);
      sb.delete();
      #2 arst = 1'b0;
      rd_ready = 1'b1;
      wr_valid = 1'b1;
      din      = 36'hC0FFEE123;
      applyStimulus();
      wr_valid = 1'b0;
      seen     = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
         if (rd_valid) begin
            seen = 1'b1;
            checkOutput("post-reset first word", dout, 36'hC0FFEE123);
         end
         applyStimulus();
      end
      checkOutput("post-reset word delivered", seen, 1);
      for (int c = 0; c < 4; c++) applyStimulus();
      checkOutput("post-reset no stale data", rd_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
